// File: rtl/fifo_write_ctrl.sv
// Write-side FIFO controller: write pointer, RAM write strobe and shared status flags.
// Flags are combinational from registered pointers; writes are refused while full.
module fifo_write_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [ADDR_W:0]   rd_ptr,
  input  logic              stat_clr,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_ptr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   fill_level,
  output logic              overflow,
  output logic [ADDR_W:0]   high_water
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  // Wrap bits differ with equal addresses: the writer is exactly one lap ahead.
  assign full        = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                       (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty       = (wr_ptr == rd_ptr);
  assign fill_level  = wr_ptr - rd_ptr;
  assign almost_full = (fill_level >= AFULL_LVL);
  assign wr_en       = wr & ~full;
  assign wr_addr     = wr_ptr[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      overflow   <= 1'b0;
      high_water <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PW'(1);

      // A rejected write in the same cycle as a clear must stay visible.
      if (wr && full)
        overflow <= 1'b1;
      else if (stat_clr)
        overflow <= 1'b0;

      if (stat_clr)
        high_water <= fill_level;
      else if (fill_level > high_water)
        high_water <= fill_level;
    end
  end

endmodule

// File: doc/fifo_write_ctrl.md
Name: fifo_write_ctrl

Overview:
- Write-side controller for the team's single-clock FIFO; counterpart to the read-pointer block.
- Owns the write pointer and write enable into the storage RAM.
- Derives the shared status flags (full, empty, almost_full, fill level) by comparing its pointer with the read pointer fed back from the read side.
- Also keeps a sticky overflow flag and a high-water mark for debug and status visibility.

Parameters:
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W = 16; pointers are ADDR_W+1 bits (extra wrap bit).
- AFULL_THRESH, 12, fill level at or above which almost_full asserts; legal range 1..2^ADDR_W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- wr  in  1  write request from producer.
- rd_ptr  in  ADDR_W+1  read pointer from read-side block, same clock domain.
- stat_clr  in  1  synchronous clear of overflow and high-water mark.
- wr_en  out  1  qualified write strobe to RAM.
- wr_ptr  out  ADDR_W+1  registered write pointer, wrap bit in MSB.
- wr_addr  out  ADDR_W  RAM write address = wr_ptr[ADDR_W-1:0].
- full  out  1  FIFO full.
- empty  out  1  FIFO empty; drives the read side's empty input.
- almost_full  out  1  fill_level >= AFULL_THRESH.
- fill_level  out  ADDR_W+1  occupied entries, 0..2^ADDR_W.
- overflow  out  1  sticky: a write was attempted while full.
- high_water  out  ADDR_W+1  maximum fill_level seen since reset or last stat_clr.

Behaviour:
- Reset (rst=0, asynchronous): wr_ptr=0, overflow=0, high_water=0. With rd_ptr=0 this gives empty=1, full=0, almost_full=0, fill_level=0, wr_en=0 (when wr=0). Reset mid-operation discards pending state immediately, with no clock required.
- wr_en = wr & ~full. This is combinational, with zero latency.
- wr_ptr <= wr_ptr + 1 when wr_en; otherwise it holds. It is modulo 2^(ADDR_W+1): 5'd31 -> 5'd0, and it wraps naturally.
- fill_level = (wr_ptr - rd_ptr), truncated to ADDR_W+1 bits. This is combinational.
- empty = (wr_ptr == rd_ptr).
- full = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]). This is equivalent to fill_level == 2^ADDR_W.
- almost_full = (fill_level >= AFULL_THRESH). This is combinational.
- All flags are combinational from the registered pointers. They are valid in the same cycle a pointer changes, so a write at edge N shows in the flags after edge N.
- Simultaneous read and write:
  - Not full, not empty: both pointers advance; fill_level is unchanged.
  - Full: the write is blocked in that cycle even if a read is in progress. There is no write-through, and overflow sets.
  - Empty: the write proceeds. The read is blocked by the read side; empty deasserts on the next cycle.
- overflow: set on any edge where wr & full. Cleared by stat_clr. If set and clear occur in the same cycle, set wins.
- high_water: on each edge, high_water <= max(high_water, fill_level). When stat_clr=1, high_water <= fill_level (current level) instead. Comparison is unsigned on ADDR_W+1 bits.
- stat_clr does not affect the pointers or flags.
- rd_ptr is trusted. Behaviour is undefined if the read side ever advances past wr_ptr. The block contains no assertion for this.

Test Plan:
- Reset then idle: rst low mid-sim -> wr_ptr=0, empty=1, full=0, fill_level=0, overflow=0, high_water=0, all without a clock edge.
- Fill: rd_ptr held 0, wr=1 for 16 cycles -> wr_ptr steps 1..16. almost_full rises when fill_level=12. full=1 and wr_en=0 after the 16th write, with wr_ptr=5'd16 and high_water=16.
- Overflow: from full, wr=1 for 3 more cycles -> wr_ptr stays 16 and overflow=1. Then stat_clr=1 with wr=1 -> overflow stays 1 (set wins). Then stat_clr=1 with wr=0 -> overflow=0 and high_water=16 (current level).
- Wrap: pre-drive rd_ptr to track; 40 writes with a concurrent read each cycle after the first -> wr_ptr passes 31->0 and wr_addr wraps 15->0. fill_level stays 1, and full never asserts falsely after the wrap.
- Full plus simultaneous read: wr_ptr=16, rd_ptr=0, wr=1 while rd_ptr steps to 1 at the same edge -> write blocked and wr_ptr stays 16. Next cycle full=0, wr_en=1, and wr_ptr becomes 17.
- High-water: write 7, drain to 2, write 3 -> high_water=7. stat_clr -> high_water=5 (current level).
